next_addr_ctrl: RTL and testbench
=================================

NEXT_ADDR_CTRL -- requirements
Module: next_addr_ctrl

Interface
REQ-001 SHALL: CP  in  1  common clock, all state updates on rising edge.
REQ-002 SHALL: RST  in  1  reset, asynchronous, active-high.
REQ-003 SHALL: MW  in  4  next-address instruction field from microprogram ROM, captured into pipeline register PIR.
REQ-004 SHALL: TEST  in  1  condition input; POL  in  1  polarity, pass = TEST XOR POL.
REQ-005 SHALL: CNT_D  in  8  loop-count load value.
REQ-006 SHALL: START  in  1  resumes from HALT.
REQ-007 SHALL: S  out  2  sequencer source select (00 uPC, 01 AR, 10 stack, 11 D).
REQ-008 SHALL: FE, PUP, RE, ZERO  out  1 each  sequencer controls, FE/RE/ZERO active-low.
REQ-009 SHALL: C  out  1  incrementer carry-in.
REQ-010 SHALL: CNT_Z  out  1  loop counter equals 0; STK_ERR  out  1  sticky stack over/underflow; HALTED  out  1.

Function
REQ-011 SHALL: PIR load MW on every CP edge while state RUN; PIR hold in HALT.
REQ-012 SHALL: S/FE/PUP/RE/ZERO/C decode combinationally from PIR, pass, state, depth, counter; default S=00, FE=1, PUP=0, RE=1, ZERO=1, C=1.
REQ-013 SHALL: opcodes: 0 JZ ZERO=0, depth:=0; 1 CONT; 2 JMP S=11; 3 CJMP S=11 if pass else CONT.
REQ-014 SHALL: 4 JSR S=11, FE=0, PUP=1; 5 CJSR same if pass else CONT; 6 RTS S=10, FE=0, PUP=0; 7 CRTS same if pass else CONT.
REQ-015 SHALL: 8 LDCT counter:=CNT_D, CONT; 9 LOOP: counter!=0 -> S=10, counter-1; counter==0 -> FE=0, PUP=0 (pop), S=00.
REQ-016 SHALL: 10 PUSH FE=0, PUP=1, S=00; 11 LDAR RE=0, CONT; 12 JRA S=01; 13 CJRA S=01 if pass else CONT.
REQ-017 SHALL: 14 WAIT S=00, C=0 while fail, C=1 on pass (holds address, no PIR change visible until pass).
REQ-018 SHALL: 15 HALT S=00, C=0, next state HALT; HALT -> RUN on CP edge with START=1, PIR then reloads from MW.
REQ-019 SHALL: in HALT all outputs default except C=0, HALTED=1.
REQ-020 SHALL: track stack depth 0..4 in 3-bit counter, +1 on issued push, -1 on issued pop.
REQ-021 SHALL: push at depth 4 or pop at depth 0 suppressed (FE forced 1), STK_ERR set, sticky until RST.
REQ-022 SHALL: counter 8-bit, decrement never wraps (LOOP at 0 pops, no decrement); CNT_Z combinational from counter.
REQ-023 SHALL: JZ resets depth to 0 regardless of issued push/pop, counter unchanged.

Reset
REQ-024 SHALL: RST asynchronously set PIR=0 (JZ), state RUN, depth 0, counter 0, STK_ERR 0.
REQ-025 SHALL: outputs during and immediately after RST: ZERO=0, S=00, FE=1, PUP=0, RE=1, C=1, CNT_Z=1, HALTED=0.
REQ-026 SHALL: RST mid-WAIT, mid-LOOP or in HALT take effect without CP edge.

Structure
REQ-027 SHALL: shared package holds 4-bit opcode constants, S encodings, state encoding (RUN, HALT), depth limit 4.
REQ-028 SHALL: one sub-module loop_counter (8-bit load/decrement/zero flag); rest inline.

Verification
REQ-029 SHALL: RST then MW=1 for 3 cycles -> first ZERO=0, then S=00, C=1, FE=1 each cycle.
REQ-030 SHALL: MW=4 (JSR) 5 times -> FE=0, PUP=1 four times, fifth FE=1, STK_ERR=1.
REQ-031 SHALL: LDCT CNT_D=3, PUSH, then LOOP repeated -> S=10 three cycles, fourth cycle FE=0, PUP=0, S=00, CNT_Z=1.
REQ-032 SHALL: CJMP with POL=1: TEST=1 -> S=00; TEST=0 -> S=11.
REQ-033 SHALL: WAIT with TEST=0 for 4 cycles -> C=0 held; TEST=1 -> C=1 same cycle.
REQ-034 SHALL: HALT -> HALTED=1, C=0, PIR frozen; START=1 -> HALTED=0 next edge; RST during HALT -> HALTED=0 immediately.

Source files
------------

// File: rtl/next_addr_ctrl_pkg.sv
// Shared constants for the next-address controller: opcodes, source selects,
// controller states and the sequencer stack depth limit.
package next_addr_ctrl_pkg;

  localparam logic [3:0] OpJz   = 4'd0;
  localparam logic [3:0] OpCont = 4'd1;
  localparam logic [3:0] OpJmp  = 4'd2;
  localparam logic [3:0] OpCjmp = 4'd3;
  localparam logic [3:0] OpJsr  = 4'd4;
  localparam logic [3:0] OpCjsr = 4'd5;
  localparam logic [3:0] OpRts  = 4'd6;
  localparam logic [3:0] OpCrts = 4'd7;
  localparam logic [3:0] OpLdct = 4'd8;
  localparam logic [3:0] OpLoop = 4'd9;
  localparam logic [3:0] OpPush = 4'd10;
  localparam logic [3:0] OpLdar = 4'd11;
  localparam logic [3:0] OpJra  = 4'd12;
  localparam logic [3:0] OpCjra = 4'd13;
  localparam logic [3:0] OpWait = 4'd14;
  localparam logic [3:0] OpHalt = 4'd15;

  localparam logic [1:0] SelUpc = 2'b00;
  localparam logic [1:0] SelAr  = 2'b01;
  localparam logic [1:0] SelStk = 2'b10;
  localparam logic [1:0] SelD   = 2'b11;

  localparam logic [2:0] DepthMax = 3'd4;

  typedef enum logic {StRun, StHalt} state_e;

endpackage

// File: rtl/next_addr_ctrl_loop_counter.sv
// 8-bit loop counter: parallel load, decrement that stops at zero, zero flag.
module loop_counter (
  input  logic       cp,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] d,
  output logic       zero
);

  logic [7:0] count_q;

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= d;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 8'd1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/next_addr_ctrl.sv
// Next-address controller: decodes the pipelined next-address field into
// sequencer controls and tracks stack depth, loop count and run/halt state.
module next_addr_ctrl
  import next_addr_ctrl_pkg::*;
(
  input  logic       cp,
  input  logic       rst,
  input  logic [3:0] mw,
  input  logic       test,
  input  logic       pol,
  input  logic [7:0] cnt_d,
  input  logic       start,
  output logic [1:0] s,
  output logic       fe,
  output logic       pup,
  output logic       re,
  output logic       zero,
  output logic       c,
  output logic       cnt_z,
  output logic       stk_err,
  output logic       halted
);

  state_e     state_q;
  logic [3:0] pir_q;
  logic [2:0] depth_q;
  logic       stk_err_q;

  logic run, pass;
  logic push_req, pop_req, err_now, push_ok, pop_ok;
  logic cnt_load, cnt_dec;

  assign run  = (state_q == StRun);
  assign pass = test ^ pol;

  always_comb begin
    s        = SelUpc;
    fe       = 1'b1;
    pup      = 1'b0;
    re       = 1'b1;
    zero     = 1'b1;
    c        = 1'b1;
    push_req = 1'b0;
    pop_req  = 1'b0;
    if (run) begin
      case (pir_q)
        OpJz:   zero = 1'b0;
        OpJmp:  s = SelD;
        OpCjmp: if (pass) s = SelD;
        OpJsr:  begin s = SelD; fe = 1'b0; pup = 1'b1; push_req = 1'b1; end
        OpCjsr: if (pass) begin s = SelD; fe = 1'b0; pup = 1'b1; push_req = 1'b1; end
        OpRts:  begin s = SelStk; fe = 1'b0; pop_req = 1'b1; end
        OpCrts: if (pass) begin s = SelStk; fe = 1'b0; pop_req = 1'b1; end
        OpLoop: begin
          // Loop back from the stack top until the count runs out, then drop it.
          if (!cnt_z) s = SelStk;
          else begin fe = 1'b0; pop_req = 1'b1; end
        end
        OpPush: begin fe = 1'b0; pup = 1'b1; push_req = 1'b1; end
        OpLdar: re = 1'b0;
        OpJra:  s = SelAr;
        OpCjra: if (pass) s = SelAr;
        OpWait: c = pass;
        OpHalt: c = 1'b0;
        default: ;
      endcase
    end else begin
      c = 1'b0;
    end
    err_now = (push_req && (depth_q == DepthMax)) || (pop_req && (depth_q == 3'd0));
    if (err_now) fe = 1'b1;
  end

  assign push_ok  = push_req && !err_now;
  assign pop_ok   = pop_req && !err_now;
  assign cnt_load = run && (pir_q == OpLdct);
  assign cnt_dec  = run && (pir_q == OpLoop);

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      state_q   <= StRun;
      pir_q     <= OpJz;
      depth_q   <= '0;
      stk_err_q <= 1'b0;
    end else begin
      if (err_now) stk_err_q <= 1'b1;
      case (state_q)
        StRun: begin
          pir_q <= mw;
          if (pir_q == OpHalt) state_q <= StHalt;
          if (pir_q == OpJz)   depth_q <= '0;
          else if (push_ok)    depth_q <= depth_q + 3'd1;
          else if (pop_ok)     depth_q <= depth_q - 3'd1;
        end
        StHalt: begin
          if (start) begin
            state_q <= StRun;
            pir_q   <= mw;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  loop_counter u_loop_counter (
    .cp   (cp),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .d    (cnt_d),
    .zero (cnt_z)
  );

  assign stk_err = stk_err_q | err_now;
  assign halted  = (state_q == StHalt);

endmodule

// File: tb/tb_next_addr_ctrl.sv
// Bench for next_addr_ctrl: an abstract instruction-level model checked every
// cycle, plus directed sequences with literal expectations.
module tb_next_addr_ctrl;

  logic       cp, rst;
  logic [3:0] mw;
  logic       test, pol, start;
  logic [7:0] cnt_d;
  logic [1:0] s;
  logic       fe, pup, re, zero, c, cnt_z, stk_err, halted;

  int tests = 0;
  int fails = 0;

  next_addr_ctrl dut (
    .cp      (cp),
    .rst     (rst),
    .mw      (mw),
    .test    (test),
    .pol     (pol),
    .cnt_d   (cnt_d),
    .start   (start),
    .s       (s),
    .fe      (fe),
    .pup     (pup),
    .re      (re),
    .zero    (zero),
    .c       (c),
    .cnt_z   (cnt_z),
    .stk_err (stk_err),
    .halted  (halted)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Instruction-level model state
  int m_pir, m_depth, m_cnt;
  bit m_err, m_halt;

  typedef struct packed {
    logic [1:0] s;
    logic fe, pup, re, zero, c, cnt_z, stk_err, halted;
  } outs_t;

  // +1 = wants push, -1 = wants pop, 0 = no stack traffic
  function automatic int stack_req(int op, bit p, int cnt);
    case (op)
      4, 10:   return 1;
      5:       return p ? 1 : 0;
      6:       return -1;
      7:       return p ? -1 : 0;
      9:       return (cnt == 0) ? -1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic bit stack_blocked(int req, int depth);
    return (req > 0 && depth >= 4) || (req < 0 && depth <= 0);
  endfunction

  function automatic outs_t predict();
    outs_t o;
    bit p;
    int req;
    bit blk;
    o = '{s: 2'd0, fe: 1'b1, pup: 1'b0, re: 1'b1, zero: 1'b1, c: 1'b1,
          cnt_z: (m_cnt == 0), stk_err: m_err, halted: m_halt};
    if (m_halt) begin
      o.c = 1'b0;
      return o;
    end
    p   = test ^ pol;
    req = stack_req(m_pir, p, m_cnt);
    blk = stack_blocked(req, m_depth);
    if (req != 0 && !blk) o.fe = 1'b0;
    if (req > 0) o.pup = 1'b1;
    if (blk) o.stk_err = 1'b1;
    case (m_pir)
      0:  o.zero = 1'b0;
      2:  o.s = 2'd3;
      3:  if (p) o.s = 2'd3;
      4:  o.s = 2'd3;
      5:  if (p) o.s = 2'd3;
      6:  o.s = 2'd2;
      7:  if (p) o.s = 2'd2;
      9:  if (m_cnt != 0) o.s = 2'd2;
      11: o.re = 1'b0;
      12: o.s = 2'd1;
      13: if (p) o.s = 2'd1;
      14: o.c = p;
      15: o.c = 1'b0;
      default: ;
    endcase
    return o;
  endfunction

  always @(posedge cp or posedge rst) begin
    if (rst) begin
      m_pir = 0; m_depth = 0; m_cnt = 0; m_err = 0; m_halt = 0;
    end else if (m_halt) begin
      if (start) begin
        m_halt = 0;
        m_pir  = int'(mw);
      end
    end else begin
      int  req;
      bit  blk;
      int  op;
      op  = m_pir;
      req = stack_req(op, test ^ pol, m_cnt);
      blk = stack_blocked(req, m_depth);
      if (op == 0) m_depth = 0;
      else if (req != 0 && !blk) m_depth = m_depth + req;
      if (blk) m_err = 1;
      if (op == 8) m_cnt = int'(cnt_d);
      if (op == 9 && m_cnt > 0) m_cnt = m_cnt - 1;
      if (op == 15) m_halt = 1;
      m_pir = int'(mw);
    end
  end

  always @(negedge cp) begin
    outs_t e;
    e = predict();
    check("cycle_model", {s, fe, pup, re, zero, c, cnt_z, stk_err, halted}, e);
  end

  task automatic tick();
    @(posedge cp);
    #3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mw = 4'd1; test = 1'b0; pol = 1'b0; cnt_d = 8'd0; start = 1'b0;
    #12;
    check("rst_zero", zero, 1'b0);
    check("rst_s", s, 2'd0);
    check("rst_fe", fe, 1'b1);
    check("rst_pup", pup, 1'b0);
    check("rst_re", re, 1'b1);
    check("rst_c", c, 1'b1);
    check("rst_cnt_z", cnt_z, 1'b1);
    check("rst_halted", halted, 1'b0);
    check("rst_stk_err", stk_err, 1'b0);
    rst = 1'b0;
    #1 check("post_rst_zero", zero, 1'b0);

    // CONT for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cont_zero", zero, 1'b1);
      check("cont_s", s, 2'd0);
      check("cont_c", c, 1'b1);
      check("cont_fe", fe, 1'b1);
    end

    // JSR five times: fifth overflows
    mw = 4'd4;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("jsr_fe", fe, 1'b0);
      check("jsr_pup", pup, 1'b1);
      check("jsr_s", s, 2'd3);
    end
    tick();
    check("jsr_ovf_fe", fe, 1'b1);
    check("jsr_ovf_err", stk_err, 1'b1);
    mw = 4'd0;
    tick();
    check("jz_zero", zero, 1'b0);
    check("err_sticky", stk_err, 1'b1);

    // LDCT 3, PUSH, LOOP x4
    mw = 4'd8; cnt_d = 8'd3;
    tick();
    mw = 4'd10;
    tick();
    check("push_fe", fe, 1'b0);
    check("push_pup", pup, 1'b1);
    check("push_cnt_z", cnt_z, 1'b0);
    mw = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("loop_s", s, 2'd2);
      check("loop_fe", fe, 1'b1);
    end
    tick();
    check("loop_end_fe", fe, 1'b0);
    check("loop_end_pup", pup, 1'b0);
    check("loop_end_s", s, 2'd0);
    check("loop_end_cnt_z", cnt_z, 1'b1);

    // CJMP with inverted polarity
    mw = 4'd3; pol = 1'b1; test = 1'b1;
    tick();
    check("cjmp_fail_s", s, 2'd0);
    test = 1'b0;
    #1 check("cjmp_pass_s", s, 2'd3);

    // WAIT
    mw = 4'd14; pol = 1'b0; test = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wait_c", c, 1'b0);
    end
    tick();
    check("wait_hold_c", c, 1'b0);
    test = 1'b1;
    #1 check("wait_pass_c", c, 1'b1);
    mw = 4'd15;

    // HALT then resume
    tick();
    check("halt_op_c", c, 1'b0);
    check("halt_op_halted", halted, 1'b0);
    mw = 4'd4;
    tick();
    check("halted", halted, 1'b1);
    check("halted_c", c, 1'b0);
    check("halted_fe", fe, 1'b1);
    tick();
    check("halted_hold", halted, 1'b1);
    check("halted_pup", pup, 1'b0);
    start = 1'b1; mw = 4'd1;
    tick();
    start = 1'b0;
    check("resume_halted", halted, 1'b0);
    check("resume_c", c, 1'b1);
    mw = 4'd15;
    tick();
    mw = 4'd1;
    tick();
    check("halt2", halted, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_halt_halted", halted, 1'b0);
    check("rst_halt_c", c, 1'b1);
    check("rst_halt_zero", zero, 1'b0);
    check("rst_halt_err", stk_err, 1'b0);
    mw = 4'd6;
    rst = 1'b0;

    // RTS at depth 0 underflows
    tick();
    check("rts_ufl_fe", fe, 1'b1);
    check("rts_ufl_s", s, 2'd2);
    check("rts_ufl_err", stk_err, 1'b1);

    // Reset mid-LOOP
    mw = 4'd8; cnt_d = 8'd5;
    tick();
    mw = 4'd9;
    tick();
    check("loop5_s", s, 2'd2);
    check("loop5_cnt_z", cnt_z, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("rst_loop_cnt_z", cnt_z, 1'b1);
    check("rst_loop_s", s, 2'd0);
    check("rst_loop_zero", zero, 1'b0);
    mw = 4'd1;
    rst = 1'b0;
    tick();
    tick();
    check("final_cont_c", c, 1'b1);

    @(posedge cp);
    #6;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
